// File: rtl/count_seq_ctrl_pkg.sv
// count_seq_ctrl_pkg: state/speed codes and 7-seg patterns shared by the counter controller
package count_seq_ctrl_pkg;
  typedef enum logic [1:0] {PAUSE = 2'd0, RUN = 2'd1, LIMIT = 2'd2} state_t;
  localparam logic [1:0] SLOW = 2'd0, NORMAL = 2'd1, FAST = 2'd2;
  localparam logic [6:0] SEG_UP = 7'b1011100, SEG_DN = 7'b1100011, SEG_BLANK = 7'b1111111;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/count_seq_ctrl_seg_scan.sv
// count_seq_ctrl_seg_scan: 4-digit multiplexed 7-seg driver (ones, tens, direction arrow, speed)
// ports: clk, rst_n (async, active-low); tens/ones BCD digits, countup, speed code;
//        digit = active-low anode select, display = active-low segments {g..a}
module count_seq_ctrl_seg_scan
  import count_seq_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       countup,
  input  logic [1:0] speed,
  output logic [3:0] digit,
  output logic [6:0] display
);
  logic [SCAN_DIV-1:0] cnt;
  logic [3:0] digit_nxt;
  logic [6:0] display_nxt;
  logic legal;
  // segments are decoded from the next digit so both registers switch on the same edge
  always_comb begin
    legal = digit == 4'b1110 || digit == 4'b1101 || digit == 4'b1011 || digit == 4'b0111;
    digit_nxt = !legal ? 4'b1110 : &cnt ? {digit[2:0], digit[3]} : digit;
    display_nxt = digit_nxt == 4'b1110 ? seg7(ones)
                : digit_nxt == 4'b1101 ? seg7(tens)
                : digit_nxt == 4'b1011 ? (countup ? SEG_UP : SEG_DN)
                : seg7({2'b00, speed});
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      digit <= 4'b1110;
      display <= 7'b1000000;
    end else begin
      cnt <= cnt + SCAN_DIV'(1);
      digit <= digit_nxt;
      display <= display_nxt;
    end
endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: run/pause/limit sequencer for a two-digit BCD up/down counter with 7-seg scan
// ports: clk, rst_n (async, active-low); en_pulse toggles run/pause, dir level (0 = up),
//        up_pulse/down_pulse speed +-1, clr_pulse soft clear; DIGIT/DISPLAY active-low display,
//        max/min limit flags, running = RUN or LIMIT
module count_seq_ctrl
  import count_seq_ctrl_pkg::*;
#(
  parameter int SLOW_DIV   = 25,
  parameter int NORMAL_DIV = 24,
  parameter int FAST_DIV   = 23,
  parameter int SCAN_DIV   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_pulse,
  input  logic       dir,
  input  logic       up_pulse,
  input  logic       down_pulse,
  input  logic       clr_pulse,
  output logic [3:0] DIGIT,
  output logic [6:0] DISPLAY,
  output logic       max,
  output logic       min,
  output logic       running
);
  localparam int PW = SLOW_DIV > NORMAL_DIV ? (SLOW_DIV > FAST_DIV ? SLOW_DIV : FAST_DIV)
                                            : (NORMAL_DIV > FAST_DIV ? NORMAL_DIV : FAST_DIV);
  state_t state, state_nxt;
  logic [3:0] tens, ones, tens_nxt, ones_nxt;
  logic [1:0] speed, speed_nxt;
  logic [PW-1:0] presc, presc_nxt, lim;
  logic countup, countup_nxt, max_nxt, min_nxt, tick, bnd, step, leave;
  int div;
  always_comb begin
    div = speed == FAST ? FAST_DIV : speed == NORMAL ? NORMAL_DIV : SLOW_DIV;
    lim = PW'((64'd1 << div) - 64'd1);
    tick = presc == lim;
    bnd = countup ? {tens, ones} == 8'h99 : {tens, ones} == 8'h00;
  end
  always_comb
    state_nxt = clr_pulse ? PAUSE
              : state == PAUSE ? (en_pulse ? RUN : PAUSE)
              : state == RUN ? (en_pulse ? PAUSE : tick && bnd ? LIMIT : RUN)
              : state == LIMIT ? (en_pulse ? PAUSE : countup == dir ? RUN : LIMIT)
              : PAUSE;
  always_comb running = state == RUN || state == LIMIT;
  // countup == dir in LIMIT means countup is about to flip away from the boundary
  always_comb begin
    step = state == RUN && !clr_pulse && !en_pulse && tick && !bnd;
    leave = state == LIMIT && state_nxt != LIMIT;
    speed_nxt = speed > FAST ? SLOW
              : up_pulse && !down_pulse && speed != FAST ? speed + 2'd1
              : down_pulse && !up_pulse && speed != SLOW ? speed - 2'd1
              : speed;
    presc_nxt = (state_nxt == PAUSE || (state_nxt == RUN && state != RUN) || speed_nxt != speed || tick)
              ? '0 : presc + PW'(1);
    ones_nxt = clr_pulse ? 4'd0
             : !step ? ones
             : countup ? (ones == 4'd9 ? 4'd0 : ones + 4'd1)
             : (ones == 4'd0 ? 4'd9 : ones - 4'd1);
    tens_nxt = clr_pulse ? 4'd0
             : !step ? tens
             : countup ? (ones == 4'd9 ? tens + 4'd1 : tens)
             : (ones == 4'd0 ? tens - 4'd1 : tens);
    countup_nxt = clr_pulse ? 1'b1 : running ? ~dir : countup;
    max_nxt = !clr_pulse && !leave && (max || (state == RUN && state_nxt == LIMIT && countup));
    min_nxt = !clr_pulse && !leave && (min || (state == RUN && state_nxt == LIMIT && !countup));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= PAUSE;
      tens <= 4'd0;
      ones <= 4'd0;
      countup <= 1'b1;
      speed <= SLOW;
      presc <= '0;
      max <= 1'b0;
      min <= 1'b0;
    end else begin
      state <= state_nxt;
      tens <= tens_nxt;
      ones <= ones_nxt;
      countup <= countup_nxt;
      speed <= speed_nxt;
      presc <= presc_nxt;
      max <= max_nxt;
      min <= min_nxt;
    end
  count_seq_ctrl_seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk(clk),
    .rst_n(rst_n),
    .tens(tens),
    .ones(ones),
    .countup(countup),
    .speed(speed),
    .digit(DIGIT),
    .display(DISPLAY)
  );
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed self-checking bench for count_seq_ctrl with short dividers
module tb_count_seq_ctrl;
  import count_seq_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en_pulse = 1'b0, dir = 1'b0, up_pulse = 1'b0, down_pulse = 1'b0, clr_pulse = 1'b0;
  logic [3:0] DIGIT;
  logic [6:0] DISPLAY;
  logic max, min, running, found;
  logic [3:0] prev;
  logic [3:0] exp_d [4];
  logic [6:0] exp_s [4];
  int total = 0, passed = 0;

  count_seq_ctrl #(.SLOW_DIV(4), .NORMAL_DIV(3), .FAST_DIV(2), .SCAN_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .en_pulse(en_pulse), .dir(dir), .up_pulse(up_pulse),
    .down_pulse(down_pulse), .clr_pulse(clr_pulse), .DIGIT(DIGIT), .DISPLAY(DISPLAY),
    .max(max), .min(min), .running(running)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic e, input logic u, input logic d, input logic c);
    en_pulse = e;
    up_pulse = u;
    down_pulse = d;
    clr_pulse = c;
    @(negedge clk);
    en_pulse = 1'b0;
    up_pulse = 1'b0;
    down_pulse = 1'b0;
    clr_pulse = 1'b0;
  endtask

  initial begin
    exp_d = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_s = '{7'b1111000, 7'b0110000, 7'b1011100, 7'b1111001};
    cyc(2);
    chk("rst_state", dut.state, PAUSE);
    chk("rst_count", {dut.tens, dut.ones}, 8'h00);
    chk("rst_countup", dut.countup, 1'b1);
    chk("rst_speed", dut.speed, 2'd0);
    chk("rst_presc", 32'(dut.presc), 0);
    chk("rst_flags", {max, min, running}, 3'b000);
    chk("rst_digit", DIGIT, 4'b1110);
    chk("rst_display", DISPLAY, 7'b1000000);
    rst_n = 1'b1;
    pulse(1, 0, 0, 0);
    cyc(15);
    chk("run_hold_00", {dut.tens, dut.ones}, 8'h00);
    cyc(1);
    chk("run_01", {dut.tens, dut.ones}, 8'h01);
    chk("running", running, 1'b1);
    cyc(16);
    chk("run_02", {dut.tens, dut.ones}, 8'h02);
    chk("run_flags", {max, min}, 2'b00);
    cyc(16 * 95);
    chk("up_97", {dut.tens, dut.ones}, 8'h97);
    cyc(16);
    chk("up_98", {dut.tens, dut.ones}, 8'h98);
    cyc(16);
    chk("up_99", {dut.tens, dut.ones}, 8'h99);
    chk("max_before", max, 1'b0);
    cyc(16);
    chk("limit_hold_99", {dut.tens, dut.ones}, 8'h99);
    chk("max_set", {max, min}, 2'b10);
    chk("limit_state", dut.state, LIMIT);
    chk("limit_running", running, 1'b1);
    dir = 1'b1;
    cyc(1);
    chk("max_clear", max, 1'b0);
    chk("limit_exit", dut.state, RUN);
    cyc(15);
    chk("down_hold_99", {dut.tens, dut.ones}, 8'h99);
    cyc(1);
    chk("down_98", {dut.tens, dut.ones}, 8'h98);
    cyc(16 * 97);
    chk("down_01", {dut.tens, dut.ones}, 8'h01);
    cyc(16);
    chk("down_00", {dut.tens, dut.ones}, 8'h00);
    chk("min_before", min, 1'b0);
    cyc(16);
    chk("min_set", {max, min}, 2'b01);
    chk("min_limit", dut.state, LIMIT);
    chk("min_hold_00", {dut.tens, dut.ones}, 8'h00);
    pulse(1, 0, 0, 0);
    chk("limit_to_pause", dut.state, PAUSE);
    chk("min_clr_exit", {max, min, running}, 3'b000);
    cyc(40);
    chk("pause_hold", {dut.tens, dut.ones}, 8'h00);
    chk("pause_presc", 32'(dut.presc), 0);
    pulse(0, 1, 0, 0);
    chk("speed_1", dut.speed, 2'd1);
    pulse(0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    chk("speed_sat", dut.speed, 2'd2);
    pulse(0, 1, 1, 0);
    chk("speed_both", dut.speed, 2'd2);
    dir = 1'b0;
    pulse(1, 0, 0, 0);
    cyc(3);
    chk("fast_hold", {dut.tens, dut.ones}, 8'h00);
    cyc(1);
    chk("fast_01", {dut.tens, dut.ones}, 8'h01);
    cyc(4);
    chk("fast_02", {dut.tens, dut.ones}, 8'h02);
    cyc(160);
    chk("fast_42", {dut.tens, dut.ones}, 8'h42);
    pulse(1, 0, 0, 1);
    chk("clr_count", {dut.tens, dut.ones}, 8'h00);
    chk("clr_state", dut.state, PAUSE);
    chk("clr_speed", dut.speed, 2'd2);
    chk("clr_misc", {dut.countup, running, max, min}, 4'b1000);
    chk("clr_presc", 32'(dut.presc), 0);
    pulse(1, 0, 0, 0);
    cyc(4);
    chk("pre_rst_01", {dut.tens, dut.ones}, 8'h01);
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk("arst_state", dut.state, PAUSE);
    chk("arst_count", {dut.tens, dut.ones}, 8'h00);
    chk("arst_speed", dut.speed, 2'd0);
    chk("arst_presc", 32'(dut.presc), 0);
    chk("arst_outs", {running, max, min, dut.countup}, 4'b0001);
    chk("arst_disp", {DIGIT, DISPLAY}, {4'b1110, 7'b1000000});
    cyc(1);
    rst_n = 1'b1;
    pulse(0, 1, 0, 0);
    chk("scan_speed", dut.speed, 2'd1);
    pulse(1, 0, 0, 0);
    cyc(296);
    chk("norm_37", {dut.tens, dut.ones}, 8'h37);
    pulse(1, 0, 0, 0);
    chk("scan_pause", {running, dut.tens, dut.ones}, {1'b0, 8'h37});
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = DIGIT;
      @(negedge clk);
      found = prev == 4'b0111 && DIGIT == 4'b1110;
    end
    chk("scan_sync", found, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("scan_first_%0d", k), {DIGIT, DISPLAY}, {exp_d[k], exp_s[k]});
      cyc(3);
      chk($sformatf("scan_last_%0d", k), {DIGIT, DISPLAY}, {exp_d[k], exp_s[k]});
      cyc(1);
    end
    chk("scan_wrap", {DIGIT, DISPLAY}, {4'b1110, 7'b1111000});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
